// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment table and decimal constants for the seg7 scanner
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int max_val(input int digits);
        return pow10(digits) - 1;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// rtl/seg7_bin2bcd.sv - clamped, one-bit-per-step double-dabble converter for one channel
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int VAL_W  = 8,
    parameter int DIGITS = 2,
    parameter int MAXV   = 99
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  step,
    input  logic [VAL_W-1:0]      value,
    output logic [4*DIGITS-1:0]   result,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;

    logic [VAL_W-1:0] bin;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    adj;
    logic             too_big;

    assign too_big = 64'(value) > 64'(MAXV);

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Accumulator value after the step in progress; the top stages this on the final step.
    assign result = BW'({adj, bin[VAL_W-1]});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin <= '0;
            bcd <= '0;
            ovf <= 1'b0;
        end else if (start) begin
            bin <= too_big ? VAL_W'(MAXV) : value;
            bcd <= '0;
            ovf <= too_big;
        end else if (step) begin
            bcd <= result;
            bin <= bin << 1;
        end
    end

endmodule

// File: rtl/seg7_scan_bcd.sv
// rtl/seg7_scan_bcd.sv - multi-channel BCD conversion with multiplexed 7-segment scan, blanking and blink
module seg7_scan_bcd
    import seg7_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DIG_PER_CH = 2,
    parameter int VAL_W      = 8,
    parameter int REFRESH_W  = 18,
    parameter int BLINK_W    = 26
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*VAL_W-1:0]   val,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [NUM_CH-1:0]         blink,
    output logic                      busy,
    output logic [NUM_CH-1:0]         ovf,
    output logic [6:0]                seg,
    output logic [NUM_CH*DIG_PER_CH-1:0] an,
    output logic                      dp
);

    localparam int ND   = NUM_CH * DIG_PER_CH;
    localparam int MAXV = max_val(DIG_PER_CH);
    localparam int KW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW   = (ND > 1) ? $clog2(ND) : 1;
    localparam int CW   = $clog2(VAL_W + 1);

    state_t state, state_nxt;
    logic capture, start, step, last, commit;

    logic [NUM_CH*VAL_W-1:0]  shadow;
    logic [KW-1:0]            k;
    logic [CW-1:0]            cnt;
    logic [4*DIG_PER_CH-1:0]  result;
    logic                     ch_ovf;
    logic [3:0]               stage [ND];
    logic [3:0]               disp  [ND];
    logic [NUM_CH-1:0]        stage_ovf;

    logic [REFRESH_W-1:0]     refresh;
    logic [BLINK_W-1:0]       blink_cnt;
    logic [SW-1:0]            scan;
    logic [ND-1:0]            blank;

    seg7_bin2bcd #(.VAL_W(VAL_W), .DIGITS(DIG_PER_CH), .MAXV(MAXV)) u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .step   (step),
        .value  (shadow[k*VAL_W +: VAL_W]),
        .result (result),
        .ovf    (ch_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: if (load) begin
                capture   = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                start     = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(VAL_W - 1)) begin
                    last      = 1'b1;
                    state_nxt = (k == KW'(NUM_CH - 1)) ? ST_COMMIT : ST_LOAD;
                end
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Results land in the staging buffer first so the display flips to a full new set in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow    <= '0;
            k         <= '0;
            cnt       <= '0;
            stage_ovf <= '0;
            ovf       <= '0;
            for (int d = 0; d < ND; d++) begin
                stage[d] <= 4'd0;
                disp[d]  <= 4'd0;
            end
        end else begin
            if (capture) begin
                shadow <= val;
                k      <= '0;
            end
            if (start) cnt <= '0;
            if (step)  cnt <= cnt + CW'(1);
            if (last) begin
                for (int j = 0; j < DIG_PER_CH; j++)
                    stage[int'(k)*DIG_PER_CH + j] <= result[4*j +: 4];
                stage_ovf[k] <= ch_ovf;
                k            <= k + KW'(1);
            end
            if (commit) begin
                for (int d = 0; d < ND; d++) disp[d] <= stage[d];
                ovf <= stage_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh   <= '0;
            blink_cnt <= '0;
            scan      <= '0;
        end else begin
            refresh   <= refresh + REFRESH_W'(1);
            blink_cnt <= blink_cnt + BLINK_W'(1);
            if (&refresh) scan <= (scan == SW'(ND - 1)) ? '0 : scan + SW'(1);
        end
    end

    // A digit is a leading zero when it and every higher digit of its channel are zero.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            zero_above = 1'b1;
            for (int j = DIG_PER_CH - 1; j >= 1; j--) begin
                zero_above = zero_above & (disp[c*DIG_PER_CH + j] == 4'd0);
                blank[c*DIG_PER_CH + j] = blank_lz & zero_above;
            end
            for (int j = 0; j < DIG_PER_CH; j++) begin
                if (blink_cnt[BLINK_W-1] & blink[c]) blank[c*DIG_PER_CH + j] = 1'b1;
            end
        end
    end

    assign seg = blank[scan] ? SEG_BLANK : seg_code(disp[scan]);
    assign an  = ~(ND'(1) << scan);
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// tb/tb_seg7_scan_bcd.sv - self-checking bench for seg7_scan_bcd against an arithmetic display model
module tb_seg7_scan_bcd;

    localparam int NUM_CH = 2;
    localparam int DPC    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] val = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [1:0]  blink = '0;
    logic        busy;
    logic [1:0]  ovf;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    seg7_scan_bcd #(
        .NUM_CH(2), .DIG_PER_CH(2), .VAL_W(8), .REFRESH_W(2), .BLINK_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .val(val), .load(load), .blank_lz(blank_lz),
        .blink(blink), .busy(busy), .ovf(ovf), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge; drives the model of the refresh and blink counters.
    int cyc;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int tests = 0;
    int fails = 0;
    int mval [NUM_CH];
    logic [1:0] movf;

    function automatic logic [6:0] ref_code(input int digit);
        case (digit)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input int n);
        int c, j, p;
        c = d / DPC;
        j = d % DPC;
        p = 1;
        for (int i = 0; i < j; i++) p = p * 10;
        if (blink[c] && (n % 8) >= 4) return 7'h7F;
        if (blank_lz && j > 0 && mval[c] < p) return 7'h7F;
        return ref_code((mval[c] / p) % 10);
    endfunction

    function automatic logic [3:0] exp_an(input int n);
        return ~(4'b0001 << ((n / 4) % 4));
    endfunction

    task automatic set_model(input logic [15:0] v);
        for (int c = 0; c < NUM_CH; c++) begin
            mval[c] = (v[c*8 +: 8] > 8'd99) ? 99 : int'(v[c*8 +: 8]);
            movf[c] = v[c*8 +: 8] > 8'd99;
        end
    endtask

    task automatic apply_load(input logic [15:0] v);
        @(negedge clk);
        val  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests++; if (ovf !== 2'b00)   begin fails++; $display("FAIL reset_ovf got=%b want=00", ovf); end
        tests++; if (an !== 4'b1110)  begin fails++; $display("FAIL reset_an got=%b want=1110", an); end
        tests++; if (seg !== 7'h40)   begin fails++; $display("FAIL reset_seg got=%h want=40", seg); end
        tests++; if (dp !== 1'b1)     begin fails++; $display("FAIL reset_dp got=%b want=1", dp); end
        mval[0] = 0; mval[1] = 0; movf = '0;
    endtask

    task automatic test_conversion();
        int n;
        blank_lz = 1'b0;
        apply_load({8'd7, 8'd42});
        wait_idle(n);
        set_model({8'd7, 8'd42});
        tests++; if (n != 19)       begin fails++; $display("FAIL conv_busy_cycles got=%0d want=19", n); end
        tests++; if (ovf !== 2'b00) begin fails++; $display("FAIL conv_ovf got=%b want=00", ovf); end
        for (int pass = 0; pass < 2; pass++) begin
            blank_lz = (pass == 1);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                tests++;
                if (an !== exp_an(cyc) || seg !== exp_seg((cyc / 4) % 4, cyc)) begin
                    fails++;
                    $display("FAIL conv_digit lz=%0d an=%b seg=%h want an=%b seg=%h", blank_lz, an, seg,
                             exp_an(cyc), exp_seg((cyc / 4) % 4, cyc));
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_overflow_ignored();
        int m;
        apply_load({8'd50, 8'd255});
        repeat (4) @(negedge clk);
        val  = {8'd50, 8'd3};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(m);
        set_model({8'd50, 8'd255});
        tests++; if (5 + m != 19)   begin fails++; $display("FAIL ovf_busy_cycles got=%0d want=19", 5 + m); end
        tests++; if (ovf !== 2'b01) begin fails++; $display("FAIL ovf_flag got=%b want=01", ovf); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || an !== exp_an(cyc) || seg !== exp_seg((cyc / 4) % 4, cyc)) begin
                fails++;
                $display("FAIL ovf_digit busy=%b an=%b seg=%h want busy=0 an=%b seg=%h", busy, an, seg,
                         exp_an(cyc), exp_seg((cyc / 4) % 4, cyc));
            end
        end
    endtask

    task automatic test_random();
        int n;
        logic [15:0] v;
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < NUM_CH; c++)
                v[c*8 +: 8] = ($urandom % 3 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            blank_lz = 1'($urandom % 2);
            apply_load(v);
            wait_idle(n);
            set_model(v);
            tests++; if (n != 19)    begin fails++; $display("FAIL rand_busy v=%h got=%0d want=19", v, n); end
            tests++; if (ovf !== movf) begin fails++; $display("FAIL rand_ovf v=%h got=%b want=%b", v, ovf, movf); end
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                tests++;
                if (an !== exp_an(cyc) || seg !== exp_seg((cyc / 4) % 4, cyc)) begin
                    fails++;
                    $display("FAIL rand_digit v=%h lz=%0d an=%b seg=%h want an=%b seg=%h", v, blank_lz, an, seg,
                             exp_an(cyc), exp_seg((cyc / 4) % 4, cyc));
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] seq [4];
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mval[0] = 0; mval[1] = 0; movf = '0;
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (an !== seq[(i / 4) % 4]) begin
                fails++;
                $display("FAIL scan_an step=%0d got=%b want=%b", i, an, seq[(i / 4) % 4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blink();
        int n, ch1_dark, ch0_dark;
        blink = 2'b00;
        apply_load({8'd58, 8'd31});
        wait_idle(n);
        set_model({8'd58, 8'd31});
        blink = 2'b10;
        ch1_dark = 0;
        ch0_dark = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an[3:2] != 2'b11 && seg === 7'h7F) ch1_dark++;
            if (an[1:0] != 2'b11 && seg === 7'h7F) ch0_dark++;
            tests++;
            if (an !== exp_an(cyc) || seg !== exp_seg((cyc / 4) % 4, cyc)) begin
                fails++;
                $display("FAIL blink_digit an=%b seg=%h want an=%b seg=%h", an, seg,
                         exp_an(cyc), exp_seg((cyc / 4) % 4, cyc));
            end
        end
        tests++; if (ch1_dark != 4) begin fails++; $display("FAIL blink_ch1_dark got=%0d want=4", ch1_dark); end
        tests++; if (ch0_dark != 0) begin fails++; $display("FAIL blink_ch0_dark got=%0d want=0", ch0_dark); end
        blink = 2'b00;
    endtask

    task automatic test_mid_reset();
        int n;
        apply_load({8'd200, 8'd88});
        wait_idle(n);
        tests++; if (ovf !== 2'b10) begin fails++; $display("FAIL midrst_pre_ovf got=%b want=10", ovf); end
        apply_load({8'd12, 8'd34});
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b want=0", busy); end
        tests++; if (ovf !== 2'b00) begin fails++; $display("FAIL midrst_ovf got=%b want=00", ovf); end
        mval[0] = 0; mval[1] = 0; movf = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || seg !== exp_seg((cyc / 4) % 4, cyc)) begin
                fails++;
                $display("FAIL midrst_digit busy=%b seg=%h want busy=0 seg=%h", busy, seg,
                         exp_seg((cyc / 4) % 4, cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_overflow_ignored();
        test_random();
        test_scan();
        test_blink();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_bcd.md
SEG7_SCAN_BCD -- requirements
Module: seg7_scan_bcd

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of displayed values (channels).
REQ-002 SHALL have parameter DIG_PER_CH, default 2, meaning decimal digits per channel.
REQ-003 SHALL have parameter VAL_W, default 8, meaning binary width of each channel value.
REQ-004 SHALL have parameter REFRESH_W, default 18, meaning each digit is lit for 2^REFRESH_W cycles.
REQ-005 SHALL have parameter BLINK_W, default 26, meaning blink period is 2^BLINK_W cycles.
REQ-006 SHALL define ND = NUM_CH*DIG_PER_CH and MAXV = 10^DIG_PER_CH-1 (default ND=4, MAXV=99).
REQ-007 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-009 SHALL have port val, input, NUM_CH*VAL_W, channel c at bits [c*VAL_W +: VAL_W].
REQ-010 SHALL have port load, input, 1, single-cycle request to convert and display val.
REQ-011 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-012 SHALL have port blink, input, NUM_CH, per-channel blink enable.
REQ-013 SHALL have port busy, output, 1, conversion in progress.
REQ-014 SHALL have port ovf, output, NUM_CH, per-channel saturation flag for the displayed values.
REQ-015 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-016 SHALL have port an, output, ND, active-low digit enables; an[0] is the rightmost digit.
REQ-017 SHALL have port dp, output, 1, tied to 1 (decimal point off).

Function
REQ-018 SHALL use digit index d = c*DIG_PER_CH + j; channel 0 is rightmost, j=0 is the ones digit.
REQ-019 SHALL run a converter FSM with states IDLE, LOAD, SHIFT, COMMIT.
REQ-020 SHALL, when load=1 in IDLE, capture val into a shadow register, set channel index k=0, and go to LOAD.
REQ-021 SHALL, in LOAD, clamp channel k to min(value, MAXV), record value>MAXV, clear BCD accumulator, and go to SHIFT.
REQ-022 SHALL, in SHIFT, perform one double-dabble iteration (add 3 to each BCD nibble >=5, then shift left 1) per cycle for exactly VAL_W cycles.
REQ-023 SHALL, after the last SHIFT cycle, store the result in a staging buffer; go to LOAD with k+1 if k<NUM_CH-1, else to COMMIT.
REQ-024 SHALL, in COMMIT, copy all staged digits and overflow flags to the display registers and ovf atomically in one cycle, then go to IDLE.
REQ-025 SHALL assert busy whenever state != IDLE; total busy time = NUM_CH*(VAL_W+1)+1 cycles (19 at defaults).
REQ-026 SHALL ignore load while busy; no queuing; display never shows partially converted data.
REQ-027 SHALL run a REFRESH_W-bit free-running counter; on its terminal count the scan index advances, wrapping ND-1 -> 0.
REQ-028 SHALL drive exactly one an bit low at all times: an = ~(1 << scan index).
REQ-029 SHALL encode digits 0..9 as seg = 7'h40,79,24,30,19,12,02,78,00,10; any other code -> 7'h7F.
REQ-030 SHALL blank (seg=7'h7F, an unchanged) digit j>0 of channel c when blank_lz=1 and digits j..DIG_PER_CH-1 of c are all zero; the ones digit is never blanked by this rule.
REQ-031 SHALL run a BLINK_W-bit free-running counter; when its MSB=1 and blink[c]=1, all digits of channel c show seg=7'h7F.
REQ-032 SHALL derive seg from registered state only (no combinational path from val or load to seg/an).

Reset
REQ-033 SHALL, with rst_n=0 at a clock edge, set state IDLE, busy 0, ovf 0, display/staging digits 0, refresh, blink and scan counters 0.
REQ-034 SHALL, after reset, output an = ~1 (one-hot to an[0]) and seg = 7'h40.
REQ-035 SHALL, when reset occurs mid-conversion, abort it; no partial commit.

Structure
REQ-036 SHALL place the FSM state enum typedef, segment code table, and a MAXV/pow10 constant function in package seg7_pkg.
REQ-037 SHALL implement the per-channel double-dabble datapath (clamp, iterate, BCD output) as sub-module seg7_bin2bcd, sequenced by the top FSM.

Verification
REQ-038 SHALL cover reset: rst_n=0 one cycle -> busy=0, ovf=0, an=4'b1110, seg=7'h40.
REQ-039 SHALL cover conversion: val={8'd7,8'd42}, load pulse -> busy high 19 cycles, then digits (d3..d0)=0,7,4,2; with blank_lz=1 digit 3 shows 7'h7F.
REQ-040 SHALL cover overflow and ignored load: ch0=8'd255 -> ovf[0]=1, digits 9,9; second load at busy cycle 5 with ch0=8'd3 -> ignored, still 99.
REQ-041 SHALL cover scan with REFRESH_W=2: an sequence 1110,1101,1011,0111,1110, each held 4 cycles.
REQ-042 SHALL cover blink with BLINK_W=3, blink=2'b10: channel 1 digits seg=7'h7F for 4 of every 8 cycles; channel 0 unaffected.
REQ-043 SHALL cover mid-conversion reset: rst_n=0 at busy cycle 10 -> busy=0 next cycle, all displayed digits 0, ovf=0.
